// File: rtl/ecc_core_pkg.sv
// Shared definitions for the ECC arithmetic core: opcodes, FSM state encoding
// and a helper that sizes the digit counter.
package ecc_core_pkg;

   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_SQR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must reach digits-1; never narrower than one bit
   // so a single-digit configuration still elaborates.
   function automatic int cntWidth(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/core_digit_mac.sv
// One digit step of the digit-serial multiplier: multiplies the full A operand
// by a single D-bit digit of B, aligns the partial product to the digit's
// weight and adds it into the running 2W-bit accumulator. Purely combinational.
module core_digit_mac
   import ecc_core_pkg::*;
#(
   parameter int W  = 128,
   parameter int D  = 8,
   parameter int CW = cntWidth(W / D)
) (
   input  logic [2*W-1:0] i_acc,
   input  logic [W-1:0]   i_a,
   input  logic [D-1:0]   i_digit,
   input  logic [CW-1:0]  i_cnt,
   output logic [2*W-1:0] o_accNext
);

   localparam int SW = $clog2(2 * W);

   logic [W+D-1:0] w_partial;
   logic [2*W-1:0] w_wide;
   logic [2*W-1:0] w_shifted;
   logic [SW-1:0]  w_shamt;

   // The partial product is at most W+D bits; both factors are widened to
   // that size so the multiply never truncates.
   assign w_partial = {{D{1'b0}}, i_a} * {{W{1'b0}}, i_digit};

   // Digit number cnt carries weight 2^(D*cnt); the largest shift is
   // D*(W/D-1), which always fits in SW bits.
   assign w_shamt   = SW'(i_cnt) * SW'(D);
   assign w_wide    = (2*W)'(w_partial);
   assign w_shifted = w_wide << w_shamt;

   // The full product fits in 2W bits, so this sum cannot overflow.
   assign o_accNext = i_acc + w_shifted;

endmodule

// File: rtl/core_op_unit.sv
// Arithmetic core for the ECC datapath. Accepts MUL, SQR and ADD requests
// through a start/busy/done handshake and produces a 2W-bit result. MUL and
// SQR run digit-serially over W/D cycles; ADD and invalid opcodes finish in a
// single step. Operands are captured on an accepted start and then held.
module core_op_unit
   import ecc_core_pkg::*;
#(
   parameter int W = 128,
   parameter int D = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2:0]     op_sel,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [2*W-1:0] c_out
);

   // W must be a multiple of D; the digit count below assumes it.
   localparam int            DIGITS = W / D;
   localparam int            CW     = cntWidth(DIGITS);
   localparam logic [CW-1:0] LAST   = CW'(DIGITS - 1);

   state_t         r_state;
   logic [W-1:0]   r_aReg;
   logic [W-1:0]   r_bReg;
   logic [2*W-1:0] r_acc;
   logic [CW-1:0]  r_cnt;
   logic           r_done;
   logic           r_err;
   logic [2*W-1:0] r_cOut;

   logic [2*W-1:0] w_accNext;
   logic [W:0]     w_sum;

   // The W+1-bit sum keeps the carry out of A+B.
   assign w_sum = {1'b0, a} + {1'b0, b};

   core_digit_mac #(
      .W  (W),
      .D  (D),
      .CW (CW)
   ) u_digitMac (
      .i_acc     (r_acc),
      .i_a       (r_aReg),
      .i_digit   (r_bReg[D-1:0]),
      .i_cnt     (r_cnt),
      .o_accNext (w_accNext)
   );

   assign busy  = (r_state != IDLE);
   assign done  = r_done;
   assign err   = r_err;
   assign c_out = r_cOut;

   // Control FSM plus datapath registers. done/err/c_out are loaded on the
   // same edge that enters DONE, so they are valid exactly while in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_aReg  <= '0;
         r_bReg  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cOut  <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  case (op_sel)
                     OP_MUL, OP_SQR: begin
                        r_aReg  <= a;
                        r_bReg  <= (op_sel == OP_SQR) ? a : b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                     end
                     OP_ADD: begin
                        r_acc   <= {{(W-1){1'b0}}, w_sum};
                        r_cOut  <= {{(W-1){1'b0}}, w_sum};
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end
                     default: begin
                        r_cOut  <= '0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                     end
                  endcase
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_acc  <= w_accNext;
               r_bReg <= r_bReg >> D;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_cOut  <= w_accNext;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_op_unit.sv
// Self-checking bench for core_op_unit (W=128, D=8). Expected results come from
// a behavioural model and are queued when an operation is issued, then popped
// and compared when the DUT raises done.
module tb_core_op_unit;

   localparam int W = 128;
   localparam int D = 8;
   localparam int MUL_LAT = W / D + 1;
   localparam int MAX_WAIT = 40;

   localparam logic [2:0] T_MUL = 3'b001;
   localparam logic [2:0] T_SQR = 3'b010;
   localparam logic [2:0] T_ADD = 3'b011;

   typedef struct packed {
      logic [2*W-1:0] c;
      logic           e;
   } exp_t;

   logic           clk;
   logic           rst;
   logic           start;
   logic [2:0]     op_sel;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic           err;
   logic [2*W-1:0] c_out;

   exp_t expQ[$];
   int   testsRun;
   int   testsFailed;

   core_op_unit #(
      .W (W),
      .D (D)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sel (op_sel),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .c_out  (c_out)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural reference using full-width arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t r;
      r.e = 1'b0;
      case (op)
         T_MUL:   r.c = (2*W)'(x) * (2*W)'(y);
         T_SQR:   r.c = (2*W)'(x) * (2*W)'(x);
         T_ADD:   r.c = (2*W)'(x) + (2*W)'(y);
         default: begin r.c = '0; r.e = 1'b1; end
      endcase
      return r;
   endfunction

   // Drives one request from the current time, lets the next rising edge
   // sample it, then scrambles the inputs so operand latching is exercised.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      start  = 1'b1;
      op_sel = op;
      a      = x;
      b      = y;
      expQ.push_back(model(op, x, y));
      @(posedge clk);
      #1;
      start  = 1'b0;
      op_sel = 3'($urandom);
      a      = {$urandom(), $urandom(), $urandom(), $urandom()};
      b      = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // Waits (bounded) for done; cyc counts sampling edges since the start edge,
   // or -1 on timeout. Returns observed outputs and the popped expectation.
   task automatic waitResult(input int startCyc, output int cyc, output logic [2*W-1:0] obsC,
                             output logic obsE, output logic [2*W-1:0] expC, output logic expE);
      exp_t ex;
      cyc = startCyc;
      while (!done && cyc < MAX_WAIT) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      obsC = c_out;
      obsE = err;
      if (done) begin
         if (expQ.size() > 0) ex = expQ.pop_front();
         else ex = '{c: {(2*W){1'bx}}, e: 1'bx};
      end else begin
         cyc = -1;
         ex  = '{c: {(2*W){1'bx}}, e: 1'bx};
      end
      expC = ex.c;
      expE = ex.e;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b want 0", err); end
      testsRun++; if (c_out !== '0) begin testsFailed++; $display("[TB] FAIL reset_cout: got %h want 0", c_out); end
      rst = 1'b0;
   endtask

   task automatic test_mul_max();
      int cyc; logic [2*W-1:0] oc, ec, k; logic oe, ee;
      k = '1;
      k = k - ((2*W)'(1) << (W + 1)) + (2*W)'(2);
      applyStimulus(T_MUL, '1, '1);
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT) begin testsFailed++; $display("[TB] FAIL mul_max_latency: got %0d want %0d", cyc, MUL_LAT); end
      testsRun++; if (oc !== ec) begin testsFailed++; $display("[TB] FAIL mul_max_model: got %h want %h", oc, ec); end
      testsRun++; if (oc !== k) begin testsFailed++; $display("[TB] FAIL mul_max_const: got %h want %h", oc, k); end
      testsRun++; if (oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_max_err: got %b want 0", oe); end
      @(posedge clk); #1;
      testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_max_pulse: got %b want 0", done); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_max_idle: got %b want 0", busy); end
   endtask

   task automatic test_sqr_and_zero();
      int cyc; logic [2*W-1:0] oc, ec; logic oe, ee;
      applyStimulus(T_SQR, W'(3), W'(16'hFFFF));
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT) begin testsFailed++; $display("[TB] FAIL sqr_latency: got %0d want %0d", cyc, MUL_LAT); end
      testsRun++; if (oc !== (2*W)'(9) || oc !== ec) begin testsFailed++; $display("[TB] FAIL sqr_result: got %h want 9", oc); end
      @(posedge clk); #1;
      applyStimulus(T_MUL, W'(0), W'(5));
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT) begin testsFailed++; $display("[TB] FAIL mul_zero_latency: got %0d want %0d", cyc, MUL_LAT); end
      testsRun++; if (oc !== ec) begin testsFailed++; $display("[TB] FAIL mul_zero_result: got %h want %h", oc, ec); end
   endtask

   task automatic test_add();
      int cyc; logic [2*W-1:0] oc, ec; logic oe, ee;
      @(posedge clk); #1;
      applyStimulus(T_ADD, '1, W'(1));
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== 1) begin testsFailed++; $display("[TB] FAIL add_latency: got %0d want 1", cyc); end
      testsRun++; if (oc !== ((2*W)'(1) << W) || oc !== ec) begin testsFailed++; $display("[TB] FAIL add_result: got %h want %h", oc, ec); end
      testsRun++; if (oe !== ee) begin testsFailed++; $display("[TB] FAIL add_err: got %b want %b", oe, ee); end
   endtask

   task automatic test_invalid();
      int cyc; logic [2*W-1:0] oc, ec; logic oe, ee;
      logic [2:0] ops [3];
      ops[0] = 3'b111; ops[1] = 3'b000; ops[2] = 3'b100;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         applyStimulus(ops[i], W'(123 + i), W'(456));
         waitResult(1, cyc, oc, oe, ec, ee);
         testsRun++; if (cyc !== 1) begin testsFailed++; $display("[TB] FAIL inv_latency op=%b: got %0d want 1", ops[i], cyc); end
         testsRun++; if (oe !== 1'b1 || oe !== ee) begin testsFailed++; $display("[TB] FAIL inv_err op=%b: got %b want 1", ops[i], oe); end
         testsRun++; if (oc !== ec) begin testsFailed++; $display("[TB] FAIL inv_cout op=%b: got %h want %h", ops[i], oc, ec); end
         @(posedge clk); #1;
         testsRun++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL inv_after op=%b: got busy/done/err %b%b%b want 000", ops[i], busy, done, err); end
      end
   endtask

   task automatic test_random();
      int cyc; logic [2*W-1:0] oc, ec; logic oe, ee;
      logic [2:0] op; int lat;
      for (int i = 0; i < 6; i++) begin
         op  = (i % 3 == 0) ? T_MUL : ((i % 3 == 1) ? T_SQR : T_ADD);
         lat = (op == T_ADD) ? 1 : MUL_LAT;
         @(posedge clk); #1;
         applyStimulus(op, {$urandom(), $urandom(), $urandom(), $urandom()},
                           {$urandom(), $urandom(), $urandom(), $urandom()});
         waitResult(1, cyc, oc, oe, ec, ee);
         testsRun++; if (cyc !== lat) begin testsFailed++; $display("[TB] FAIL rand_latency %0d: got %0d want %0d", i, cyc, lat); end
         testsRun++; if (oc !== ec || oe !== ee) begin testsFailed++; $display("[TB] FAIL rand_result %0d: got %h/%b want %h/%b", i, oc, oe, ec, ee); end
      end
   endtask

   task automatic test_start_in_run();
      int cyc; int extra; logic [2*W-1:0] oc, ec; logic oe, ee;
      @(posedge clk); #1;
      applyStimulus(T_MUL, W'(1000), W'(77));
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; op_sel = T_ADD; a = W'(5); b = W'(6);
      @(posedge clk); #1;
      start = 1'b0;
      waitResult(4, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT) begin testsFailed++; $display("[TB] FAIL run_ignore_latency: got %0d want %0d", cyc, MUL_LAT); end
      testsRun++; if (oc !== ec) begin testsFailed++; $display("[TB] FAIL run_ignore_result: got %h want %h", oc, ec); end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL run_ignore_extra_done: got %0d want 0", extra); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic [2*W-1:0] oc, ec; logic oe, ee;
      applyStimulus(T_MUL, W'(32'hDEADBEEF), W'(32'h12345678));
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT || oc !== ec) begin testsFailed++; $display("[TB] FAIL b2b_first: got %0d/%h want %0d/%h", cyc, oc, MUL_LAT, ec); end
      testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_busy_done: got %b want 1", busy); end
      applyStimulus(T_SQR, {$urandom(), $urandom(), $urandom(), $urandom()}, W'(9));
      testsRun++; if (busy !== 1'b1 || done !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_accept: got busy/done %b%b want 10", busy, done); end
      waitResult(1, cyc, oc, oe, ec, ee);
      testsRun++; if (cyc !== MUL_LAT) begin testsFailed++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", cyc, MUL_LAT); end
      testsRun++; if (oc !== ec || oe !== ee) begin testsFailed++; $display("[TB] FAIL b2b_second_result: got %h want %h", oc, ec); end
   endtask

   task automatic test_reset_mid_run();
      int extra;
      @(posedge clk); #1;
      applyStimulus(T_MUL, W'(999), W'(888));
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
      testsRun++; if (c_out !== '0) begin testsFailed++; $display("[TB] FAIL midrst_cout: got %h want 0", c_out); end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL midrst_done: got %0d want 0", extra); end
      rst = 1'b1; start = 1'b1; op_sel = T_ADD; a = W'(7); b = W'(8);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      testsRun++; if (busy !== 1'b0 || done !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_start_same: got busy/done %b%b want 00", busy, done); end
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL rst_start_activity: got %0d want 0", extra); end
   endtask

   // Test sequence and summary.
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst    = 1'b1;
      start  = 1'b0;
      op_sel = 3'b000;
      a      = '0;
      b      = '0;
      test_reset();
      test_mul_max();
      test_sqr_and_zero();
      test_add();
      test_invalid();
      test_random();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
